// File: rtl/meas_tx_pkg.sv
// meas_tx_pkg: shared FSM state type, framing constants and checksum helper
// for the measurement transmit framer.
// Build option: define MEAS_TX_TIMESTAMP_EN to add the 16-bit timestamp
// bytes (TSH/TSL) to every frame header.
package meas_tx_pkg;

    // All framer states. TSH/TSL are only visited in timestamp builds.
    typedef enum logic [3:0] {
        ST_IDLE,
        ST_SYNC,
        ST_SEQ,
        ST_LEN,
        ST_TSH,
        ST_TSL,
        ST_HI,
        ST_LO,
        ST_CSUM
    } state_t;

    // Default frame start marker.
    localparam logic [7:0] SYNC_BYTE_DEFAULT = 8'hA5;

    // Width of one measurement sample.
    localparam int SAMPLE_W = 12;

    // Header bytes in front of the sample payload: SYNC, SEQ, LEN (+ TSH, TSL).
`ifdef MEAS_TX_TIMESTAMP_EN
    localparam int HDR_LEN = 5;
`else
    localparam int HDR_LEN = 3;
`endif

    // Running modulo-256 sum; the transmitted CSUM byte is its negation.
    function automatic logic [7:0] csum_add(input logic [7:0] acc, input logic [7:0] b);
        return acc + b;
    endfunction

endpackage

// File: rtl/meas_fifo.sv
// meas_fifo: DEPTH x WIDTH synchronous sample FIFO with first-word-fall-through
// head output, so the framer can read the oldest sample combinationally.
// The caller only pushes when not full (or when popping in the same cycle)
// and only pops when not empty. DEPTH must be a power of two, >= 2.
module meas_fifo #(
    parameter int DEPTH = 64,
    parameter int WIDTH = 12
) (
    input  logic                      clk,
    input  logic                      reset,
    input  logic                      push,
    input  logic                      pop,
    input  logic [WIDTH-1:0]          din,
    output logic [WIDTH-1:0]          head,
    output logic [$clog2(DEPTH):0]    level,
    output logic                      full,
    output logic                      empty
);

    localparam int AW = $clog2(DEPTH);
    localparam int LW = AW + 1;
    localparam logic [LW-1:0] DEPTH_LV = LW'(DEPTH);

    logic [WIDTH-1:0] mem [DEPTH];
    logic [AW-1:0]    wr_ptr_reg;
    logic [AW-1:0]    rd_ptr_reg;
    logic [LW-1:0]    level_reg;

    // Sample storage; contents need no reset because the pointers define validity.
    always_ff @(posedge clk) begin
        if (push) begin
            mem[wr_ptr_reg] <= din;
        end
    end

    // Pointer and occupancy bookkeeping; simultaneous push/pop keeps level.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            wr_ptr_reg <= '0;
            rd_ptr_reg <= '0;
            level_reg  <= '0;
        end else begin
            if (push) begin
                wr_ptr_reg <= wr_ptr_reg + 1'b1;
            end
            if (pop) begin
                rd_ptr_reg <= rd_ptr_reg + 1'b1;
            end
            case ({push, pop})
                2'b10:   level_reg <= level_reg + 1'b1;
                2'b01:   level_reg <= level_reg - 1'b1;
                default: level_reg <= level_reg;
            endcase
        end
    end

    assign head  = mem[rd_ptr_reg];
    assign level = level_reg;
    assign full  = (level_reg == DEPTH_LV);
    assign empty = (level_reg == '0);

endmodule

// File: rtl/meas_tx.sv
// meas_tx: buffers 12-bit measurement samples and packetises them into
// checksummed frames written byte-wise into the FT245 write FIFO.
// Frame: SYNC, SEQ, N, [TSH, TSL], N x {HI, LO}, CSUM, where CSUM makes the
// sum of SEQ..CSUM zero modulo 256 (SYNC excluded).
// Build option: MEAS_TX_TIMESTAMP_EN adds a free-running 16-bit cycle counter
// captured at frame start and sent as TSH/TSL after the length byte.
module meas_tx
    import meas_tx_pkg::*;
#(
    parameter int         SPF       = 48,
    parameter int         DEPTH     = 64,
    parameter logic [7:0] SYNC_BYTE = SYNC_BYTE_DEFAULT
) (
    input  logic                      clk,
    input  logic                      reset,
    input  logic                      enable,
    input  logic                      flush,
    input  logic                      smp_valid,
    input  logic [SAMPLE_W-1:0]       smp_data,
    input  logic                      wr_full,
    output logic                      wr_en,
    output logic [7:0]                wr_data,
    output logic                      busy,
    output logic [7:0]                frame_seq,
    output logic                      overflow,
    output logic [$clog2(DEPTH):0]    level
);

    localparam int LW = $clog2(DEPTH) + 1;
    localparam logic [LW-1:0] SPF_LV = LW'(SPF);

    state_t              state_reg;
    logic [7:0]          len_reg;
    logic [7:0]          rem_reg;
    logic [7:0]          seq_reg;
    logic [7:0]          csum_reg;
    logic                ovf_reg;

    logic [SAMPLE_W-1:0] fifo_head;
    logic [LW-1:0]       fifo_level;
    logic                fifo_full;
    logic                fifo_empty;
    logic                push;
    logic                pop;
    logic                start;
    logic [7:0]          n_start;
    logic [7:0]          tx_byte;

    // Sample buffer; the framer reads its head directly in HI/LO.
    meas_fifo #(
        .DEPTH (DEPTH),
        .WIDTH (SAMPLE_W)
    ) u_fifo (
        .clk   (clk),
        .reset (reset),
        .push  (push),
        .pop   (pop),
        .din   (smp_data),
        .head  (fifo_head),
        .level (fifo_level),
        .full  (fifo_full),
        .empty (fifo_empty)
    );

    // A full buffer can still accept a sample when the LO byte pops one this cycle.
    assign pop  = (state_reg == ST_LO) && wr_en;
    assign push = smp_valid && enable && (!fifo_full || pop);

    // Frame trigger from IDLE: a full frame's worth buffered, or a flush with data.
    assign start   = (state_reg == ST_IDLE) &&
                     ((enable && (fifo_level >= SPF_LV)) || (flush && !fifo_empty));
    assign n_start = 8'((fifo_level >= SPF_LV) ? SPF_LV : fifo_level);

    // Every non-IDLE state presents one byte; it moves only when the FIFO has room.
    assign busy  = (state_reg != ST_IDLE);
    assign wr_en = busy && !wr_full;

`ifdef MEAS_TX_TIMESTAMP_EN
    logic [15:0] ts_cnt_reg;
    logic [15:0] ts_reg;

    // Free-running cycle counter used as the frame timestamp source.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            ts_cnt_reg <= '0;
        end else begin
            ts_cnt_reg <= ts_cnt_reg + 16'd1;
        end
    end

    // Snapshot of the counter taken when the frame leaves IDLE.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            ts_reg <= '0;
        end else if (start) begin
            ts_reg <= ts_cnt_reg;
        end
    end
`endif

    // Byte presented for the current state; held stable until it transfers.
    always_comb begin
        tx_byte = 8'h00;
        case (state_reg)
            ST_SYNC: tx_byte = SYNC_BYTE;
            ST_SEQ:  tx_byte = seq_reg;
            ST_LEN:  tx_byte = len_reg;
`ifdef MEAS_TX_TIMESTAMP_EN
            ST_TSH:  tx_byte = ts_reg[15:8];
            ST_TSL:  tx_byte = ts_reg[7:0];
`endif
            ST_HI:   tx_byte = {4'h0, fifo_head[11:8]};
            ST_LO:   tx_byte = fifo_head[7:0];
            ST_CSUM: tx_byte = 8'h00 - csum_reg;
            default: tx_byte = 8'h00;
        endcase
    end

    assign wr_data = tx_byte;

    // Checksum accumulates every transferred byte from SEQ up to the last LO.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            csum_reg <= '0;
        end else if (start) begin
            csum_reg <= '0;
        end else if (wr_en && (state_reg != ST_SYNC) && (state_reg != ST_CSUM)) begin
            csum_reg <= csum_add(csum_reg, tx_byte);
        end
    end

    // Framer FSM: advances one state per transferred byte, N latched at IDLE exit.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_reg <= ST_IDLE;
            len_reg   <= '0;
            rem_reg   <= '0;
            seq_reg   <= '0;
        end else begin
            case (state_reg)
                ST_IDLE: begin
                    if (start) begin
                        state_reg <= ST_SYNC;
                        len_reg   <= n_start;
                        rem_reg   <= n_start;
                    end
                end
                ST_SYNC: if (wr_en) state_reg <= ST_SEQ;
                ST_SEQ:  if (wr_en) state_reg <= ST_LEN;
                // Timestamp bytes follow the length only when the header is extended.
                ST_LEN:  if (wr_en) state_reg <= (HDR_LEN == 5) ? ST_TSH : ST_HI;
                ST_TSH:  if (wr_en) state_reg <= ST_TSL;
                ST_TSL:  if (wr_en) state_reg <= ST_HI;
                ST_HI:   if (wr_en) state_reg <= ST_LO;
                ST_LO: begin
                    if (wr_en) begin
                        rem_reg   <= rem_reg - 8'd1;
                        state_reg <= (rem_reg == 8'd1) ? ST_CSUM : ST_HI;
                    end
                end
                ST_CSUM: begin
                    if (wr_en) begin
                        state_reg <= ST_IDLE;
                        seq_reg   <= seq_reg + 8'd1;
                    end
                end
                default: state_reg <= ST_IDLE;
            endcase
        end
    end

    // Sticky drop indicator: an accepted-window sample found no room.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            ovf_reg <= 1'b0;
        end else if (smp_valid && enable && !push) begin
            ovf_reg <= 1'b1;
        end
    end

    assign frame_seq = seq_reg;
    assign overflow  = ovf_reg;
    assign level     = fifo_level;

endmodule

// File: tb/tb_meas_tx.sv
// tb_meas_tx: randomized and directed stimulus for meas_tx, checked against a
// frame-level reference model (sample queue + expected byte list). Expected
// bytes go into a scoreboard queue; a separate monitor compares each DUT write.
module tb_meas_tx;

    localparam int SPF   = 4;
    localparam int DEPTH = 8;
    localparam int LW    = $clog2(DEPTH) + 1;

    logic          clk = 1'b0;
    logic          reset = 1'b1;
    logic          enable = 1'b0;
    logic          flush = 1'b0;
    logic          smp_valid = 1'b0;
    logic [11:0]   smp_data = '0;
    logic          wr_full = 1'b0;
    logic          wr_en;
    logic [7:0]    wr_data;
    logic          busy;
    logic [7:0]    frame_seq;
    logic          overflow;
    logic [LW-1:0] level;

    always #5 clk = ~clk;

    meas_tx #(
        .SPF       (SPF),
        .DEPTH     (DEPTH),
        .SYNC_BYTE (8'hA5)
    ) dut (
        .clk       (clk),
        .reset     (reset),
        .enable    (enable),
        .flush     (flush),
        .smp_valid (smp_valid),
        .smp_data  (smp_data),
        .wr_full   (wr_full),
        .wr_en     (wr_en),
        .wr_data   (wr_data),
        .busy      (busy),
        .frame_seq (frame_seq),
        .overflow  (overflow),
        .level     (level)
    );

    int n_cmp = 0;
    int n_bad = 0;

    // Scoreboard of bytes the DUT must write, in order.
    logic [7:0]  exp_q[$];

    // Reference model state.
    logic [8:0]  frm_q[$];   // remaining bytes of the frame in flight; bit 8 marks a LO byte
    logic [11:0] smp_q[$];   // buffered samples, oldest first
    logic [7:0]  seq_m = '0;
    logic        ovf_m = 1'b0;
    logic [15:0] cyc_m = '0; // clock edges since reset release

    task automatic check(input string name, input int act, input int req);
        n_cmp++;
        if (act != req) begin
            n_bad++;
            $display("FAIL %s: got %0h, expected %0h (t=%0t)", name, act, req, $time);
        end
    endtask

    // Build the full byte list of a frame from the first n buffered samples.
    task automatic build_frame(input int n);
        logic [7:0]  sum;
        logic [11:0] s;
        sum = 8'h00;
        frm_q.push_back({1'b0, 8'hA5});
        frm_q.push_back({1'b0, seq_m});      sum += seq_m;
        frm_q.push_back({1'b0, 8'(n)});      sum += 8'(n);
`ifdef MEAS_TX_TIMESTAMP_EN
        frm_q.push_back({1'b0, cyc_m[15:8]}); sum += cyc_m[15:8];
        frm_q.push_back({1'b0, cyc_m[7:0]});  sum += cyc_m[7:0];
`endif
        for (int i = 0; i < n; i++) begin
            s = smp_q[i];
            frm_q.push_back({1'b0, 4'h0, s[11:8]}); sum += {4'h0, s[11:8]};
            frm_q.push_back({1'b1, s[7:0]});        sum += s[7:0];
        end
        frm_q.push_back({1'b0, 8'h00 - sum});
        $display("frame seq=%02h n=%0d bytes=%0d t=%0t", seq_m, n, frm_q.size(), $time);
    endtask

    // Advance the model by one clock edge using the inputs present at that edge.
    task automatic model_step();
        logic [8:0] b;
        bit         popped;
        int         lvl;
        popped = 0;
        lvl    = smp_q.size();
        if (frm_q.size() != 0) begin
            if (!wr_full) begin
                b = frm_q.pop_front();
                if (b[8]) popped = 1;
                if (frm_q.size() == 0) seq_m++;
            end
        end else if ((enable && lvl >= SPF) || (flush && lvl > 0)) begin
            build_frame((lvl >= SPF) ? SPF : lvl);
        end
        if (popped) void'(smp_q.pop_front());
        if (smp_valid && enable) begin
            if (lvl < DEPTH || popped) smp_q.push_back(smp_data);
            else ovf_m = 1'b1;
        end
        cyc_m++;
    endtask

    // One clock cycle: drive inputs, check outputs against the model, then step it.
    task automatic cycle(input logic en, input logic fl, input logic sv,
                         input logic [11:0] sd, input logic wf);
        logic       exp_en;
        logic [8:0] head;
        @(negedge clk);
        enable = en; flush = fl; smp_valid = sv; smp_data = sd; wr_full = wf;
        #1;
        exp_en = (frm_q.size() != 0) && !wr_full;
        check("wr_en", int'(wr_en), int'(exp_en));
        check("busy", int'(busy), int'(frm_q.size() != 0));
        check("level", int'(level), smp_q.size());
        check("overflow", int'(overflow), int'(ovf_m));
        check("frame_seq", int'(frame_seq), int'(seq_m));
        if (exp_en) begin
            head = frm_q[0];
            exp_q.push_back(head[7:0]);
        end
        @(posedge clk);
        model_step();
    endtask

    // Asynchronous reset asserted between edges; outputs must clear at once.
    task automatic do_reset();
        @(negedge clk);
        #1;
        reset = 1'b1; enable = 1'b0; flush = 1'b0; smp_valid = 1'b0; wr_full = 1'b0;
        #1;
        check("rst_wr_en", int'(wr_en), 0);
        check("rst_wr_data", int'(wr_data), 0);
        check("rst_busy", int'(busy), 0);
        check("rst_frame_seq", int'(frame_seq), 0);
        check("rst_overflow", int'(overflow), 0);
        check("rst_level", int'(level), 0);
        frm_q.delete(); smp_q.delete(); exp_q.delete();
        seq_m = '0; ovf_m = 1'b0; cyc_m = '0;
        @(posedge clk);
        @(negedge clk);
        reset = 1'b0;
        @(posedge clk);
        model_step();
    endtask

    // Monitor: every DUT byte write is matched against the scoreboard head.
    always @(negedge clk) begin
        logic [7:0] e;
        #2;
        if (!reset && wr_en) begin
            if (exp_q.size() == 0) begin
                n_cmp++;
                n_bad++;
                $display("FAIL wr_data: got %02h, expected no write (t=%0t)", wr_data, $time);
            end else begin
                e = exp_q.pop_front();
                check("wr_data", int'(wr_data), int'(e));
            end
        end
    end

    initial begin
        do_reset();

        // Two samples then flush: A5 00 02 01 23 0A BC 14.
        cycle(1, 0, 1, 12'h123, 0);
        cycle(1, 0, 1, 12'hABC, 0);
        cycle(1, 1, 0, 12'h000, 0);
        repeat (12) cycle(1, 0, 0, 12'h000, 0);

        // Same frame with a 5-cycle stall on the LO byte.
        cycle(1, 0, 1, 12'h123, 0);
        cycle(1, 0, 1, 12'hABC, 0);
        cycle(1, 1, 0, 12'h000, 0);
        repeat (4) cycle(1, 0, 0, 12'h000, 0);
        repeat (5) cycle(1, 0, 0, 12'h000, 1);
        repeat (10) cycle(1, 0, 0, 12'h000, 0);

        // Short flushed frame of three samples.
        cycle(1, 0, 1, 12'h001, 0);
        cycle(1, 0, 1, 12'h002, 0);
        cycle(1, 0, 1, 12'h003, 0);
        cycle(1, 1, 0, 12'h000, 0);
        repeat (14) cycle(1, 0, 0, 12'h000, 0);

        // Overfill while the write FIFO is full: two samples dropped.
        for (int i = 0; i < DEPTH + 2; i++) cycle(1, 0, 1, 12'(12'h100 + i), 1);
        repeat (3) cycle(1, 0, 0, 12'h000, 1);
        repeat (40) cycle(1, 0, 0, 12'h000, 0);

        // Reset while the HI byte is on the bus, then a fresh frame.
        for (int i = 0; i < SPF; i++) cycle(1, 0, 1, 12'(12'h200 + i), 0);
        repeat (4) cycle(1, 0, 0, 12'h000, 0);
        do_reset();
        cycle(1, 0, 1, 12'h7E5, 0);
        cycle(1, 1, 0, 12'h000, 0);
        repeat (8) cycle(1, 0, 0, 12'h000, 0);

        // Randomized traffic with stalls, flushes, enable gaps and resets.
        for (int i = 0; i < 3000; i++) begin
            if ($urandom_range(0, 799) == 0) begin
                do_reset();
            end else begin
                cycle(logic'($urandom_range(0, 9) != 0),
                      logic'($urandom_range(0, 19) == 0),
                      logic'($urandom_range(0, 9) < 4),
                      12'($urandom),
                      logic'($urandom_range(0, 3) == 0));
            end
        end

        // Drain whatever frame is still in flight.
        repeat (40) cycle(1, 0, 0, 12'h000, 0);
        check("scoreboard_drain", exp_q.size(), 0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule

// File: doc/meas_tx.md
Name: meas_tx

Overview:
- Transmit-side framer for the front-end link. It is the counterpart of the command receiver that feeds the FT245 read FIFO.
- Buffers 12-bit measurement samples and packetises them into checksummed frames. Frames are written byte-wise into the FT245 write FIFO (wr_en/wr_data/wr_full).
- Sits between the measurement capture path and the ft245 async FIFO, in the CLK_25M domain.

Parameters:
- SPF, 48: samples per full frame (1..255).
- DEPTH, 64: internal sample buffer depth (power of 2, >= SPF).
- SYNC_BYTE, 8'hA5: frame start marker.

Ports:
- clk  in  1  system clock (CLK_25M).
- reset  in  1  asynchronous, active-high reset.
- enable  in  1  accept samples / start frames when high.
- flush  in  1  one-cycle pulse: send a short frame of the buffered samples.
- smp_valid  in  1  sample strobe, one sample per cycle max.
- smp_data  in  12  measurement sample.
- wr_full  in  1  FT245 write FIFO full.
- wr_en  out  1  byte write strobe.
- wr_data  out  8  byte to FIFO.
- busy  out  1  frame in progress.
- frame_seq  out  8  sequence number of the next frame.
- overflow  out  1  sticky: a sample was dropped.
- level  out  $clog2(DEPTH)+1  buffer occupancy.

Behaviour:
- Reset (async, active-high) values:
  - wr_en=0, wr_data=0, busy=0, frame_seq=0, overflow=0, level=0.
  - State=IDLE; buffer emptied.
- Frame format (bytes, in order):
  - SYNC_BYTE, SEQ, N, then N x {HI={4'h0,s[11:8]}, LO=s[7:0]}, then CSUM.
  - CSUM is the 8-bit two's complement of the sum of SEQ..last LO, so the sum of SEQ..CSUM mod 256 = 0. SYNC_BYTE is excluded from the checksum.
- Byte handshake:
  - A byte transfers on a clk edge where wr_en=1.
  - wr_en = (state emits a byte) && !wr_full, combinational from wr_full and registered state.
  - wr_data is stable while in a byte state.
  - The state advances only on a transfer. While wr_full=1 the FSM holds, wr_en=0, no bytes are lost.
- FSM states: IDLE, SYNC, SEQ, LEN, HI, LO, CSUM.
  - IDLE->SYNC when enable && level>=SPF (N=SPF), or on flush && level>0 (N=min(level,SPF)).
  - N is latched at IDLE exit. A flush with level=0 is ignored. A flush while busy is ignored.
  - SYNC->SEQ->LEN->HI.
  - HI->LO. LO pops one sample, then goes to HI if samples remain, else CSUM.
  - CSUM->IDLE; frame_seq increments (wraps 255->0) on the CSUM transfer.
  - busy=1 in every state except IDLE.
- enable low:
  - New samples are not accepted.
  - A frame in progress completes.
  - No new frame starts except via flush.
- Buffer behaviour:
  - A sample is pushed on smp_valid && enable when level<DEPTH, or when level=DEPTH and a pop occurs in the same cycle.
  - Otherwise the sample is dropped and overflow sets. overflow clears only on reset.
  - Simultaneous push and pop leaves level unchanged.
- Latency:
  - From the trigger condition seen in IDLE to the first wr_en: 1 cycle, given wr_full=0.
  - A full frame with wr_full=0 takes 2N+4 consecutive cycles.
- Reset mid-frame: the frame is abandoned immediately and the partial frame is not completed. The receiver resynchronises on SYNC_BYTE.

Optional Feature:
- Macro: MEAS_TX_TIMESTAMP_EN.
- When defined:
  - A free-running 16-bit cycle counter (reset to 0) is captured at IDLE exit.
  - Two extra states TSH and TSL, between LEN and HI, emit ts[15:8] then ts[7:0].
  - Both bytes are included in CSUM. Frame length becomes 2N+6.
- When undefined: no counter, frame as above.

Decomposition:
- meas_tx_pkg holds:
  - the state enum (incl. TSH/TSL),
  - the SYNC_BYTE default,
  - the header length constant (3, or 5 with timestamp),
  - a checksum-accumulate function.
- Sub-module meas_fifo: synchronous FIFO, DEPTH x 12, push/pop/level/full/empty, first-word-fall-through so HI/LO read the head combinationally.

Test Plan:
- SPF=2, enable=1, push 12'h123, 12'hABC, wr_full=0 -> bytes A5 00 02 01 23 0A BC 14 on consecutive wr_en cycles; frame_seq becomes 1.
- Same frame with wr_full held high for 5 cycles at the LO byte -> wr_en=0 during the stall, byte 23 emitted once after release, identical byte stream.
- SPF=48, push 3 samples 12'h001, 12'h002, 12'h003, pulse flush -> A5 00 03 00 01 00 02 00 03 F7.
- DEPTH=4, wr_full=1, push 6 samples -> level=4, overflow=1, the last 2 samples absent from the next frame.
- Assert reset during a HI byte -> wr_en=0 and busy=0 immediately, frame_seq=0, level=0; after release, the next frame starts with A5 00.
- With MEAS_TX_TIMESTAMP_EN: check that bytes 4–5 equal the counter value at frame start and that the frame checksum sums to 0.
